// File: rtl/core_lsu_if.sv
// core_lsu_if: core request/writeback and data-memory handshakes of the load/store unit
interface core_lsu_if #(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 32,
   parameter int rd_width_p   = 6
) ();
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic                    req_wen_i;
   logic                    req_byte_i;
   logic [addr_width_p-1:0] req_addr_i;
   logic [data_width_p-1:0] req_data_i;
   logic [rd_width_p-1:0]   req_rd_i;
   logic                    resp_valid_o;
   logic                    resp_yumi_i;
   logic [data_width_p-1:0] resp_data_o;
   logic [rd_width_p-1:0]   resp_rd_o;
   logic                    mem_valid_o;
   logic                    mem_wen_o;
   logic                    mem_byte_not_word_o;
   logic [addr_width_p-1:0] mem_addr_o;
   logic [data_width_p-1:0] mem_wdata_o;
   logic                    mem_yumi_i;
   logic                    mem_valid_i;
   logic [data_width_p-1:0] mem_rdata_i;
   logic                    mem_yumi_o;
   modport slave (
      input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_data_i, req_rd_i,
      input  resp_yumi_i, mem_yumi_i, mem_valid_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o,
      output mem_valid_o, mem_wen_o, mem_byte_not_word_o, mem_addr_o, mem_wdata_o, mem_yumi_o
   );
   modport master (
      output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_data_i, req_rd_i,
      output resp_yumi_i, mem_yumi_i, mem_valid_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o,
      input  mem_valid_o, mem_wen_o, mem_byte_not_word_o, mem_addr_o, mem_wdata_o, mem_yumi_o
   );
endinterface

// File: rtl/core_lsu.sv
// core_lsu: in-order load/store unit with up to max_outstanding_p requests in flight
module core_lsu #(
   parameter int data_width_p       = 32,
   parameter int addr_width_p       = 32,
   parameter int rd_width_p         = 6,
   parameter int max_outstanding_p  = 2,
   parameter int sign_extend_byte_p = 0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   core_lsu_if.slave                              bus,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                   busy_o,
   output logic                                   err_o
);
   localparam int cw_lp = $clog2(max_outstanding_p + 1);
   localparam int pw_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

   logic                    r_pend, r_wen, r_byte, r_err;
   logic [addr_width_p-1:0] r_addr;
   logic [data_width_p-1:0] r_data;
   logic [cw_lp-1:0]        r_count;
   logic [pw_lp-1:0]        r_wptr, r_rptr;
   logic                    r_fifo_load [max_outstanding_p];
   logic                    r_fifo_byte [max_outstanding_p];
   logic [rd_width_p-1:0]   r_fifo_rd   [max_outstanding_p];
   logic                    w_accept, w_retire, w_empty, w_head_load, w_head_byte, w_sext;

   assign w_empty     = (r_count == '0);
   assign w_head_load = r_fifo_load[r_rptr];
   assign w_head_byte = r_fifo_byte[r_rptr];
   assign w_sext      = (sign_extend_byte_p != 0) && bus.mem_rdata_i[7];
   assign w_accept    = bus.req_valid_i && bus.req_ready_o;
   assign w_retire    = bus.mem_valid_i && bus.mem_yumi_o && !w_empty;

   assign bus.req_ready_o         = !r_pend && (r_count < cw_lp'(max_outstanding_p));
   assign bus.mem_valid_o         = r_pend;
   assign bus.mem_wen_o           = r_wen;
   assign bus.mem_byte_not_word_o = r_byte;
   assign bus.mem_addr_o          = r_addr;
   assign bus.mem_wdata_o         = r_data;
   assign outstanding_o           = r_count;
   assign busy_o                  = !w_empty;
   assign err_o                   = r_err;

   // Response steering: stores retire silently, loads wait for the core to take the writeback
   always_comb begin
      bus.resp_valid_o = !w_empty && w_head_load && bus.mem_valid_i;
      bus.mem_yumi_o   = (!w_empty && w_head_load) ? (bus.mem_valid_i && bus.resp_yumi_i) : bus.mem_valid_i;
      bus.resp_rd_o    = r_fifo_rd[r_rptr];
      bus.resp_data_o  = w_head_byte ? {{(data_width_p-8){w_sext}}, bus.mem_rdata_i[7:0]} : bus.mem_rdata_i;
   end

   // Request stage: holds one memory request stable until the memory accepts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= 1'b0;
         r_wen  <= 1'b0;
         r_byte <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_pend <= 1'b1;
         r_wen  <= bus.req_wen_i;
         r_byte <= bus.req_byte_i;
         r_addr <= bus.req_addr_i;
         r_data <= bus.req_data_i;
      end else if (bus.mem_yumi_i) begin
         r_pend <= 1'b0;
      end
   end

   // Tracking FIFO: remembers kind and destination of each in-flight request in issue order
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < max_outstanding_p; i++) begin
            r_fifo_load[i] <= 1'b0;
            r_fifo_byte[i] <= 1'b0;
            r_fifo_rd[i]   <= '0;
         end
      end else begin
         if (w_accept) begin
            r_fifo_load[r_wptr] <= !bus.req_wen_i;
            r_fifo_byte[r_wptr] <= bus.req_byte_i;
            r_fifo_rd[r_wptr]   <= bus.req_rd_i;
            r_wptr <= (r_wptr == pw_lp'(max_outstanding_p - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_retire)
            r_rptr <= (r_rptr == pw_lp'(max_outstanding_p - 1)) ? '0 : r_rptr + 1'b1;
      end
   end

   // Outstanding count and sticky error for responses nobody asked for
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept && !w_retire) r_count <= r_count + 1'b1;
         else if (w_retire && !w_accept) r_count <= r_count - 1'b1;
         if (bus.mem_valid_i && w_empty) r_err <= 1'b1;
      end
   end
endmodule
